// File: rtl/dmem_bytelane_if.sv
// Request/response bus of the byte-lane data memory.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready; the
// request fields are sampled at that edge. rsp_valid pulses for exactly one cycle, one cycle
// after each transfer, and carries no ready (the requester must always accept it).
interface dmem_bytelane_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory with byte/half/word access, load extension and a post-reset clear.
// Define DMEM_ERR_EN to flag misaligned/illegal-size accesses (store suppressed, load returns 0).
module dmem_bytelane #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_bytelane_if.slave        bus,
  output logic                  busy,
  output logic                  dbg_state
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CLR_W = ADDR_W - LB;

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CLR_W-1:0]  clr_ptr;
  logic              clear_we;
  logic              accept;
  logic [7:0]        mem [DEPTH];

  logic              legal;
  logic [1:0]        eff_size;
  logic [BYTES-1:0]  byte_en;
  logic [DATA_W-1:0] rd_bytes;
  logic [DATA_W-1:0] ext_data;
  logic              sign_bit;
  logic [7:0]        fill;
  logic              acc_err;

  // State register and clear pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (clear_we) clr_ptr <= clr_ptr + CLR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_ptr == {CLR_W{1'b1}}) state_nxt = S_IDLE;
  end

  always_comb begin
    clear_we      = (state == S_CLEAR);
    bus.req_ready = (state == S_IDLE);
    busy          = (state == S_CLEAR);
  end

  assign dbg_state = state;
  assign accept    = bus.req_valid && bus.req_ready;

  // Sizes wider than the data path fall back to a full-width access.
  always_comb begin
    legal    = (int'(bus.req_size) <= LB);
    eff_size = legal ? bus.req_size : 2'(LB);
    sign_bit = 1'b0;
    for (int k = 0; k < BYTES; k++) begin
      byte_en[k]       = ((k >> eff_size) == 0);
      rd_bytes[8*k +: 8] = mem[bus.req_addr + ADDR_W'(k)];
      if (byte_en[k]) sign_bit = rd_bytes[8*k+7];
    end
    fill = bus.req_unsigned ? 8'h00 : {8{sign_bit}};
    for (int j = 0; j < BYTES; j++) begin
      ext_data[8*j +: 8] = byte_en[j] ? rd_bytes[8*j +: 8] : fill;
    end
  end

`ifdef DMEM_ERR_EN
  logic [ADDR_W-1:0] align_mask;
  assign align_mask = ~({ADDR_W{1'b1}} << eff_size);
  assign acc_err    = !legal || ((bus.req_addr & align_mask) != '0);
`else
  assign acc_err = 1'b0;
`endif

  // Array write port: the clear sequencer owns it while busy, stores otherwise.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      for (int k = 0; k < BYTES; k++) mem[{clr_ptr, LB'(k)}] <= 8'h00;
    end else if (accept && bus.req_we && !acc_err) begin
      for (int k = 0; k < BYTES; k++) begin
        if (byte_en[k]) mem[bus.req_addr + ADDR_W'(k)] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_err <= acc_err;
        if (!bus.req_we) bus.rsp_rdata <= acc_err ? '0 : ext_data;
      end
    end
  end
endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed self-checking bench for dmem_bytelane (ADDR_W=10, DATA_W=32).
module tb_dmem_bytelane;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int WORDS  = 256;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic dbg_state;
  int   total = 0;
  int   bad = 0;

  dmem_bytelane_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_bytelane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: called just after a falling edge, the request is taken at the next rising edge.
  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  task automatic idle_req();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
  endtask

  task automatic test_reset();
    int early;
    early = 0;
    reset = 1'b1;
    idle_req();
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: busy=%b ready=%b rsp_valid=%b rdata=%h err=%b, want 1 0 0 0 0",
               busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    reset = 1'b0;
    for (int i = 1; i < WORDS; i++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0 || busy !== 1'b1) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL clear_hold: ready/idle seen in %0d of first 255 cycles, want 0", early);
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_rise: ready=%b busy=%b after 256 cycles, want 1 0", bus.req_ready, busy);
    end
  endtask

  task automatic test_sign_ext();
    logic [1:0]  sz  [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2};
    logic        un  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0]  ad  [6] = '{10'd13, 10'd14, 10'd14, 10'd15, 10'd15, 10'd12};
    logic [31:0] ex  [6] = '{32'h00000078, 32'hFFFF8911, 32'h00008911,
                             32'hFFFFFF89, 32'h00000089, 32'h89117843};
    drive_req(1'b1, 2'd2, 1'b0, 10'd12, 32'h89117843);
    @(negedge clk);
    idle_req();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL store_rsp: valid=%b rdata=%h err=%b, want 1 00000000 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b0, sz[i], un[i], ad[i], 32'h0);
      @(negedge clk);
      idle_req();
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ex[i]) begin
        bad++;
        $display("FAIL load_ext_%0d: valid=%b rdata=%h, want 1 %h", i, bus.rsp_valid, bus.rsp_rdata, ex[i]);
      end
    end
  endtask

  task automatic test_raw();
    drive_req(1'b1, 2'd2, 1'b0, 10'd4, 32'h99127254);
    @(negedge clk);
    drive_req(1'b1, 2'd0, 1'b0, 10'd5, 32'h000000AB);
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h89117843) begin
      bad++;
      $display("FAIL store_hold_rdata: valid=%b rdata=%h, want 1 89117843", bus.rsp_valid, bus.rsp_rdata);
    end
    drive_req(1'b0, 2'd2, 1'b0, 10'd4, 32'h0);
    @(negedge clk);
    drive_req(1'b1, 2'd1, 1'b0, 10'd6, 32'h0000BEEF);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h9912AB54) begin
      bad++;
      $display("FAIL raw_byte: valid=%b rdata=%h, want 1 9912AB54", bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
    drive_req(1'b0, 2'd2, 1'b1, 10'd4, 32'h0);
    @(negedge clk);
    drive_req(1'b0, 2'd1, 1'b0, 10'd6, 32'h0);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hBEEFAB54) begin
      bad++;
      $display("FAIL raw_half: valid=%b rdata=%h, want 1 BEEFAB54", bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
    idle_req();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFFFFBEEF) begin
      bad++;
      $display("FAIL half_sign: valid=%b rdata=%h, want 1 FFFFBEEF", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_wrap();
    logic        we [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [7] = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd1, 2'd2, 2'd2};
    logic [9:0]  ad [7] = '{10'd1020, 10'd0, 10'd0, 10'd1022, 10'd1023, 10'd1022, 10'd1020};
    logic [31:0] wd [7] = '{32'h22110000, 32'h00004433, 32'h0, 32'h0, 32'h0, 32'hDDCCBBAA, 32'h0};
    logic [31:0] ex [7];
    logic        er [7];
    ex[0] = 32'hFFFFBEEF;                              er[0] = 1'b0;
    ex[1] = 32'hFFFFBEEF;                              er[1] = 1'b0;
    ex[2] = ERR_EN ? 32'h0 : 32'h00004433;             er[2] = ERR_EN;
    ex[3] = ERR_EN ? 32'h0 : 32'h44332211;             er[3] = ERR_EN;
    ex[4] = ERR_EN ? 32'h0 : 32'h00003322;             er[4] = ERR_EN;
    ex[5] = ex[4];                                     er[5] = ERR_EN;
    ex[6] = ERR_EN ? 32'h22110000 : 32'hBBAA0000;      er[6] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_req(we[i], sz[i], 1'b0, ad[i], wd[i]);
      @(negedge clk);
      idle_req();
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ex[i] || bus.rsp_err !== er[i]) begin
        bad++;
        $display("FAIL wrap_%0d: valid=%b rdata=%h err=%b, want 1 %h %b",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, ex[i], er[i]);
      end
    end
    drive_req(1'b0, 2'd2, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    idle_req();
    total++;
    if (bus.rsp_rdata !== (ERR_EN ? 32'h00004433 : 32'h0000DDCC) || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_low_word: rdata=%h err=%b, want %h 0", bus.rsp_rdata, bus.rsp_err,
               ERR_EN ? 32'h00004433 : 32'h0000DDCC);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last_rd;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          pulses;
    pulses  = 0;
    last_rd = ERR_EN ? 32'h00004433 : 32'h0000DDCC;
    for (int i = 0; i < 10; i++) begin
      data = 32'h12345670 + (i / 2) * 32'h01010101;
      drive_req((i % 2) == 0, 2'd2, 1'b0, 10'(10'h100 + 4 * (i / 2)), data);
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
      exp_rd = ((i % 2) == 0) ? last_rd : data;
      last_rd = exp_rd;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_rd) begin
        bad++;
        $display("FAIL b2b_%0d: valid=%b rdata=%h, want 1 %h", i, bus.rsp_valid, bus.rsp_rdata, exp_rd);
      end
    end
    idle_req();
    @(negedge clk);
    if (bus.rsp_valid === 1'b1) pulses++;
    total++;
    if (pulses != 10) begin
      bad++;
      $display("FAIL b2b_pulses: %0d rsp_valid pulses, want 10", pulses);
    end
  endtask

  task automatic test_reset_mid_clear();
    int early;
    int seen;
    early = 0;
    seen  = 0;
    drive_req(1'b0, 2'd2, 1'b0, 10'd12, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) seen++;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
      if (bus.req_ready !== 1'b0) early++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) seen++;
    reset = 1'b0;
    for (int i = 1; i < WORDS; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
      if (bus.req_ready !== 1'b0) early++;
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL restart_ready: ready=%b 256 cycles after second release, want 1", bus.req_ready);
    end
    idle_req();
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0) seen++;
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL restart_hold: ready seen in %0d clear cycles, want 0", early);
    end
    total++;
    if (seen != 0 || bus.rsp_rdata !== '0) begin
      bad++;
      $display("FAIL dropped_rsp: rsp_valid seen %0d times, rdata=%h, want 0 00000000", seen, bus.rsp_rdata);
    end
  endtask

  task automatic test_clear_zero();
    int nz;
    int first_bad;
    nz = 0;
    first_bad = -1;
    for (int w = 0; w < WORDS; w++) begin
      drive_req(1'b0, 2'd2, 1'b1, 10'(4 * w), 32'h0);
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
        nz++;
        if (first_bad < 0) first_bad = 4 * w;
      end
    end
    idle_req();
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL clear_zero: %0d words not zero (first @%0d), want 0", nz, first_bad);
    end
  endtask

  initial begin
    idle_req();
    test_reset();
    test_sign_ext();
    test_raw();
    test_wrap();
    test_back_to_back();
    test_reset_mid_clear();
    test_clear_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
